// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S receiver defaults, receiver state encoding and channel codes.
`timescale 1ns/1ps
package audio_pkg;

  localparam int I2S_SAMPLE_W_DEFAULT = 16;
  localparam int I2S_SLOT_MAX_DEFAULT = 32;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings lrck/bck/data into the clk domain through 2-flop synchronizers and
// registers a one-cycle bck rising-edge strobe aligned with lrck_s/data_s.
`timescale 1ns/1ps
module i2s_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i2s_lrck,
  input  logic i2s_bck,
  input  logic i2s_data,
  output logic lrck_s,
  output logic data_s,
  output logic bck_rise
);

  // Bit order in both stages: {lrck, bck, data}
  logic [2:0] meta;
  logic [2:0] sync;
  logic       bck_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= '0;
      sync     <= '0;
      bck_d    <= 1'b0;
      bck_rise <= 1'b0;
      lrck_s   <= 1'b0;
      data_s   <= 1'b0;
    end else begin
      meta     <= {i2s_lrck, i2s_bck, i2s_data};
      sync     <= meta;
      bck_d    <= sync[1];
      bck_rise <= sync[1] & ~bck_d;
      // Data and word select are captured in the same stage as the strobe.
      lrck_s   <= sync[2];
      data_s   <= sync[0];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// Standard-format I2S receiver: oversamples lrck/bck/data and emits stereo frames.
// Optional build macro I2S_RX_PEAK_EN adds per-channel magnitude peak holders.
`timescale 1ns/1ps
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W_DEFAULT,
  parameter int MAX_SLOT = I2S_SLOT_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i2s_lrck,
  input  logic                i2s_bck,
  input  logic                i2s_data,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                sample_valid,
  output logic                frame_err,
  output logic                locked
`ifdef I2S_RX_PEAK_EN
  ,
  input  logic                peak_clear,
  output logic [SAMPLE_W-2:0] left_peak,
  output logic [SAMPLE_W-2:0] right_peak
`endif
);

  localparam int                CNT_W   = $clog2(MAX_SLOT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_SLOT);
  localparam logic [CNT_W:0]    LEN_MIN = (CNT_W + 1)'(SAMPLE_W);
  localparam logic [CNT_W:0]    LEN_MAX = (CNT_W + 1)'(MAX_SLOT);

  logic lrck_s, data_s, bck_rise;

  i2s_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .i2s_lrck (i2s_lrck),
    .i2s_bck  (i2s_bck),
    .i2s_data (i2s_data),
    .lrck_s   (lrck_s),
    .data_s   (data_s),
    .bck_rise (bck_rise)
  );

  rx_state_t           state, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] shreg, shreg_in, left_hold;
  logic                prev_lrck, left_done;
  logic                chg, len_ok, slot_end, slot_err;
  logic [CNT_W:0]      slot_len;
  logic [CNT_W-1:0]    cnt_inc;

  assign chg      = (lrck_s != prev_lrck);
  // Slot length counts the change-edge bit, which is the LSB of the ending slot.
  assign slot_len = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign len_ok   = (slot_len >= LEN_MIN) && (slot_len <= LEN_MAX);
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign locked   = (state == RUN);

  // MSB-first placement; bit indices at or beyond SAMPLE_W match no position and drop out.
  always_comb begin
    shreg_in = shreg;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(cnt) == SAMPLE_W - 1 - i) shreg_in[i] = data_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state;
    slot_end = 1'b0;
    slot_err = 1'b0;
    if (bck_rise) begin
      unique case (state)
        SYNC: if (chg) state_d = RUN;
        RUN: begin
          if (chg) begin
            if (len_ok) begin
              slot_end = 1'b1;
            end else begin
              slot_err = 1'b1;
              state_d  = SYNC;
            end
          end else if (cnt == CNT_MAX) begin
            slot_err = 1'b1;
            state_d  = SYNC;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      prev_lrck    <= 1'b0;
      left_done    <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= slot_err;
      if (bck_rise) begin
        prev_lrck <= lrck_s;
        // Any slot boundary, error or SYNC edge restarts the slot from a clean shift register.
        if (state == RUN && !chg && !slot_err) begin
          cnt   <= cnt_inc;
          shreg <= shreg_in;
        end else begin
          cnt   <= '0;
          shreg <= '0;
        end
        if (slot_end && prev_lrck == CH_LEFT) begin
          left_hold <= shreg_in;
          left_done <= 1'b1;
        end else if (slot_end && prev_lrck == CH_RIGHT && left_done) begin
          left_data    <= left_hold;
          right_data   <= shreg_in;
          sample_valid <= 1'b1;
          left_done    <= 1'b0;
        end else if (state_d != state) begin
          left_done <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  // Magnitude of a two's-complement sample; the most negative code saturates to all-ones.
  function automatic logic [SAMPLE_W-2:0] magnitude(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = -s;
    if (!s[SAMPLE_W-1])     return s[SAMPLE_W-2:0];
    else if (neg[SAMPLE_W-1]) return '1;
    else                    return neg[SAMPLE_W-2:0];
  endfunction

  logic [SAMPLE_W-2:0] left_mag, right_mag;
  assign left_mag  = magnitude(left_data);
  assign right_mag = magnitude(right_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_peak  <= '0;
      right_peak <= '0;
    end else if (peak_clear) begin
      left_peak  <= '0;
      right_peak <= '0;
    end else if (sample_valid) begin
      if (left_mag > left_peak)   left_peak  <= left_mag;
      if (right_mag > right_peak) right_peak <= right_mag;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table of stereo streams plus hand-written error, latency and reset sequences.
`timescale 1ns/1ps
module tb_i2s_rx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2s_lrck, i2s_bck, i2s_data;
  logic [15:0] left_data, right_data;
  logic        sample_valid, frame_err, locked;
`ifdef I2S_RX_PEAK_EN
  logic        peak_clear = 1'b0;
  logic [14:0] left_peak, right_peak;
`endif

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_W(16), .MAX_SLOT(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i2s_lrck     (i2s_lrck),
    .i2s_bck      (i2s_bck),
    .i2s_data     (i2s_data),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .locked       (locked)
`ifdef I2S_RX_PEAK_EN
    ,
    .peak_clear   (peak_clear),
    .left_peak    (left_peak),
    .right_peak   (right_peak)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Pulse monitor, sampled on the falling edge.
  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (sample_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (sample_valid && frame_err) overlap_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic q_l[$];
  logic q_d[$];

  // One slot, MSB first from val[31]; the last bit already carries the next slot's lrck.
  task automatic push_slot(input logic ch, input logic [31:0] val, input int n, input logic next_ch);
    logic [31:0] sh;
    sh = val;
    for (int k = 0; k < n; k++) begin
      q_l.push_back((k == n - 1) ? next_ch : ch);
      q_d.push_back(sh[31]);
      sh = sh << 1;
    end
  endtask

  task automatic push_frame(input int slot, input logic [31:0] lv, input logic [31:0] rv);
    push_slot(CH_LEFT, lv, slot, CH_RIGHT);
    push_slot(CH_RIGHT, rv, slot, CH_LEFT);
  endtask

  // bck = clk/8; lrck/data change on the falling bck edge. Entered and left #1 after a posedge.
  task automatic send_bit(input logic l, input logic d);
    i2s_bck  = 1'b0;
    i2s_lrck = l;
    i2s_data = d;
    repeat (4) @(posedge clk);
    #1 i2s_bck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic play();
    logic l, d;
    while (q_l.size() > 0) begin
      l = q_l.pop_front();
      d = q_d.pop_front();
      send_bit(l, d);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef I2S_RX_PEAK_EN
  task automatic clear_on_valid(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        peak_clear = 1'b1;
        hit = 1'b1;
      end
    end
    @(negedge clk);
    peak_clear = 1'b0;
  endtask
`endif

  typedef struct {
    int          slot;
    logic [31:0] lv;
    logic [31:0] rv;
    int          frames;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, e0;
    logic [6:0] pat;
    bit hit;

    vecs[0] = '{16, 32'h1234_0000, 32'hABCD_0000, 4, 16'h1234, 16'hABCD};
    vecs[1] = '{32, 32'h1234_5600, 32'hFEDC_BA00, 3, 16'h1234, 16'hFEDC};
    vecs[2] = '{24, 32'h8001_FF00, 32'h7FFE_1200, 2, 16'h8001, 16'h7FFE};
    vecs[3] = '{16, 32'h0001_0000, 32'h8000_0000, 2, 16'h0001, 16'h8000};
    vecs[4] = '{17, 32'h0000_8000, 32'h5555_8000, 2, 16'h0000, 16'h5555};

    @(posedge clk); #1;
    do_reset();
    check("reset_left", left_data, 16'h0);
    check("reset_right", right_data, 16'h0);
    check("reset_valid", sample_valid, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_locked", locked, 1'b0);

    // The first frame of each stream only achieves lock, so frames-1 samples are expected.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      v0 = valid_cnt; e0 = err_cnt;
      for (int f = 0; f < vecs[i].frames; f++) push_frame(vecs[i].slot, vecs[i].lv, vecs[i].rv);
      play();
      check($sformatf("v%0d_valid_count", i), valid_cnt - v0, vecs[i].frames - 1);
      check($sformatf("v%0d_err_count", i), err_cnt - e0, 0);
      check($sformatf("v%0d_left", i), left_data, vecs[i].el);
      check($sformatf("v%0d_right", i), right_data, vecs[i].er);
      check($sformatf("v%0d_locked", i), locked, 1'b1);
    end

    // Short 12-bit left slot inside a 16-bit stream.
    do_reset();
    v0 = valid_cnt; e0 = err_cnt;
    push_frame(16, 32'h1234_0000, 32'hABCD_0000);
    push_frame(16, 32'h1234_0000, 32'hABCD_0000);
    play();
    check("short_pre_valid", valid_cnt - v0, 1);
    check("short_pre_locked", locked, 1'b1);
    push_slot(CH_LEFT, 32'h0F0F_0000, 12, CH_RIGHT);
    play();
    check("short_err_count", err_cnt - e0, 1);
    check("short_locked", locked, 1'b0);
    check("short_left_held", left_data, 16'h1234);
    check("short_right_held", right_data, 16'hABCD);
    push_slot(CH_RIGHT, 32'h9999_0000, 16, CH_LEFT);
    push_frame(16, 32'h0F0F_0000, 32'hF0F0_0000);
    play();
    check("short_resume_valid", valid_cnt - v0, 2);
    check("short_resume_left", left_data, 16'h0F0F);
    check("short_resume_right", right_data, 16'hF0F0);
    check("short_resume_err", err_cnt - e0, 1);

    // lrck stuck for longer than the maximum slot.
    do_reset();
    e0 = err_cnt;
    push_frame(16, 32'h0, 32'h0);
    push_slot(CH_LEFT, 32'h0, 40, CH_LEFT);
    play();
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_locked", locked, 1'b0);

    // Latency from the raw bck rise that completes the right slot.
    do_reset();
    push_frame(16, 32'h1234_0000, 32'hABCD_0000);
    push_slot(CH_LEFT, 32'h1234_0000, 16, CH_RIGHT);
    push_slot(CH_RIGHT, 32'hABCD_0000, 15, CH_RIGHT);
    play();
    i2s_bck = 1'b0; i2s_lrck = CH_LEFT; i2s_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 i2s_bck = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat[i] = sample_valid;
    end
    check("latency_pattern", pat, 7'b0010000);
    check("latency_left", left_data, 16'h1234);
    check("latency_right", right_data, 16'hABCD);
    @(posedge clk); #1;

    // Reset asserted in the middle of a right slot.
    do_reset();
    v0 = valid_cnt;
    push_frame(16, 32'h1111_0000, 32'h2222_0000);
    push_frame(16, 32'h1111_0000, 32'h2222_0000);
    push_slot(CH_LEFT, 32'h3333_0000, 16, CH_RIGHT);
    push_slot(CH_RIGHT, 32'h4444_0000, 8, CH_RIGHT);
    play();
    check("midrst_pre_valid", valid_cnt - v0, 1);
    check("midrst_pre_right", right_data, 16'h2222);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hold_left", left_data, 16'h0);
    check("midrst_hold_right", right_data, 16'h0);
    check("midrst_hold_locked", locked, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    v0 = valid_cnt;
    push_slot(CH_RIGHT, 32'h0, 8, CH_LEFT);
    push_frame(16, 32'h5555_0000, 32'h6666_0000);
    play();
    check("midrst_no_early_valid", valid_cnt - v0, 0);
    check("midrst_left_still_zero", left_data, 16'h0);
    push_frame(16, 32'h7777_0000, 32'h8888_0000);
    play();
    check("midrst_resume_valid", valid_cnt - v0, 1);
    check("midrst_resume_left", left_data, 16'h7777);
    check("midrst_resume_right", right_data, 16'h8888);

`ifdef I2S_RX_PEAK_EN
    do_reset();
    push_frame(16, 32'h0, 32'h0);
    push_frame(16, 32'h0100_0000, 32'hFFFF_0000);
    push_frame(16, 32'h8000_0000, 32'h0002_0000);
    push_frame(16, 32'h7FFF_0000, 32'hFFFE_0000);
    play();
    check("peak_left", left_peak, 15'h7FFF);
    check("peak_right", right_peak, 15'h0002);
    push_frame(16, 32'h1000_0000, 32'h1000_0000);
    fork
      play();
      clear_on_valid(hit);
    join
    check("peak_clear_seen_valid", hit, 1'b1);
    check("peak_clear_left", left_peak, 15'h0);
    check("peak_clear_right", right_peak, 15'h0);
    check("peak_clear_data", left_data, 16'h1000);
`endif

    check("valid_err_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
